// File: rtl/bit8_multi_pkg.sv
// Shared types and sizing constants for the bit8_multi sign-magnitude multiplier.
package bit8_multi_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/bit8_multi_shift_add.sv
// Shift-and-add datapath: operand shift registers, 2*WIDTH accumulator and step counter.
// One partial product per step; load has priority over step, reset over both.
module bit8_multi_shift_add
  import bit8_multi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   i1,
  input  logic [WIDTH-1:0]   i2,
  output logic [2*WIDTH-1:0] acc,
  output logic [CW-1:0]      cnt
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, i1};
      mplier <= i2;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/bit8_multi.sv
// Sequential sign-magnitude multiplier; done pulses WIDTH+1 cycles after the start edge.
// start is only taken in IDLE or DONE; BIT8_MULTI_FULL_EN adds the untruncated p_full output.
module bit8_multi
  import bit8_multi_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   i1,
  input  logic [WIDTH-1:0]   i2,
  input  logic               s1,
  input  logic               s2,
`ifdef BIT8_MULTI_FULL_EN
  output logic [2*WIDTH-1:0] p_full,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   o,
  output logic               s,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIN_CNT   = CW'(WIDTH);

  state_t             state;
  logic               sgn;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  assign load = start && ((state == IDLE) || (state == DONE));
  assign step = (state == CALC) && (cnt != FIN_CNT);

  bit8_multi_shift_add #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .i1   (i1),
    .i2   (i2),
    .acc  (acc),
    .cnt  (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sgn    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      o      <= '0;
      s      <= 1'b0;
      ovf    <= 1'b0;
`ifdef BIT8_MULTI_FULL_EN
      p_full <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sgn   <= s1 ^ s2;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // busy covers the WIDTH shift-add cycles; the final cycle only registers the result
          if (cnt == LAST_STEP) begin
            busy <= 1'b0;
          end
          if (cnt == FIN_CNT) begin
            o      <= acc[WIDTH-1:0];
            ovf    <= |acc[2*WIDTH-1:WIDTH];
            s      <= sgn & (|acc);
`ifdef BIT8_MULTI_FULL_EN
            p_full <= acc;
`endif
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            sgn   <= s1 ^ s2;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit8_multi.sv
// Randomized self-checking bench for bit8_multi against an arithmetic reference model.
module tb_bit8_multi;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] i1, i2;
  logic         s1, s2;
  logic         busy, done, s, ovf;
  logic [W-1:0] o;
`ifdef BIT8_MULTI_FULL_EN
  logic [2*W-1:0] p_full;
`endif

  int errors = 0;
  int checks = 0;

  // results captured by run_op
  logic [W-1:0] r_o, r_hold_o;
  logic         r_s, r_ovf;
  int           r_lat, r_busy;
  bit           r_to;
`ifdef BIT8_MULTI_FULL_EN
  logic [2*W-1:0] r_full;
`endif

  always #5 clk = ~clk;

  bit8_multi #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .i1     (i1),
    .i2     (i2),
    .s1     (s1),
    .s2     (s2),
`ifdef BIT8_MULTI_FULL_EN
    .p_full (p_full),
`endif
    .busy   (busy),
    .done   (done),
    .o      (o),
    .s      (s),
    .ovf    (ovf)
  );

  // Launch one multiply at a negedge and wait (bounded) for done; optionally
  // scramble operands and poke start while the unit is busy.
  task automatic run_op(input int a, input int b, input bit sa, input bit sb, input bit disturb);
    i1 = W'(a); i2 = W'(b); s1 = sa; s2 = sb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_hold_o = o;
    r_lat = 0; r_busy = 0; r_to = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) r_busy++;
      if (disturb) begin
        i1 = W'($urandom); i2 = W'($urandom);
        s1 = 1'($urandom); s2 = 1'($urandom);
        start = (busy === 1'b1);
      end
      @(negedge clk);
      start = 1'b0;
      r_lat++;
      if (r_lat > 40) begin
        r_to = 1'b1;
        break;
      end
    end
    start = 1'b0;
    r_o = o; r_s = s; r_ovf = ovf;
`ifdef BIT8_MULTI_FULL_EN
    r_full = p_full;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    i1 = W'($urandom); i2 = W'($urandom); s1 = 1'b1; s2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (o !== '0) begin errors++; $display("FAIL reset_o: got %0d expected 0", o); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL reset_s: got %b expected 0", s); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`ifdef BIT8_MULTI_FULL_EN
    checks++; if (p_full !== '0) begin errors++; $display("FAIL reset_pfull: got %0d expected 0", p_full); end
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_quiet: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_directed();
    int ta[6] = '{3, 3, 100, 1, 5, 0};
    int tb[6] = '{2, 81, 50, 1, 7, 9};
    bit tsa[6] = '{0, 0, 0, 0, 1, 1};
    int prod;
    for (int k = 0; k < 6; k++) begin
      run_op(ta[k], tb[k], tsa[k], 1'b0, 1'b0);
      prod = ta[k] * tb[k];
      checks++; if (r_to) begin errors++; $display("FAIL dir%0d_timeout: got no done expected done", k); end
      checks++; if (r_lat != W + 1) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, r_lat, W + 1); end
      checks++; if (r_busy != W) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", k, r_busy, W); end
      checks++; if (r_o !== W'(prod % 256)) begin errors++; $display("FAIL dir%0d_o: got %0d expected %0d", k, r_o, prod % 256); end
      checks++; if (r_ovf !== (prod > 255)) begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", k, r_ovf, prod > 255); end
      checks++; if (r_s !== ((prod != 0) && tsa[k])) begin errors++; $display("FAIL dir%0d_s: got %b expected %b", k, r_s, (prod != 0) && tsa[k]); end
`ifdef BIT8_MULTI_FULL_EN
      checks++; if (r_full !== 16'(prod)) begin errors++; $display("FAIL dir%0d_pfull: got %0d expected %0d", k, r_full, prod); end
`endif
      @(negedge clk);
      checks++; if (done !== 1'b0 || o !== W'(prod % 256)) begin errors++; $display("FAIL dir%0d_hold: got done=%b o=%0d expected done=0 o=%0d", k, done, o, prod % 256); end
    end
  endtask

  task automatic test_disturb();
    int a, b, prod;
    bit sa, sb;
    for (int k = 0; k < 6; k++) begin
      a = (k == 0) ? 0 : int'($urandom_range(0, 255));
      b = (k == 0) ? 9 : int'($urandom_range(0, 255));
      sa = (k == 0) ? 1'b1 : 1'($urandom);
      sb = (k == 0) ? 1'b0 : 1'($urandom);
      run_op(a, b, sa, sb, 1'b1);
      prod = a * b;
      checks++; if (r_to || r_lat != W + 1) begin errors++; $display("FAIL dist%0d_latency: got %0d expected %0d", k, r_lat, W + 1); end
      checks++; if ({r_o, r_ovf, r_s} !== {W'(prod % 256), prod > 255, (prod != 0) && (sa ^ sb)})
        begin errors++; $display("FAIL dist%0d_result: got o=%0d ovf=%b s=%b expected o=%0d ovf=%b s=%b (a=%0d b=%0d)", k, r_o, r_ovf, r_s, prod % 256, prod > 255, (prod != 0) && (sa ^ sb), a, b); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int a0, b0, a1, b1, p0, p1;
    a0 = int'($urandom_range(1, 255)); b0 = int'($urandom_range(1, 255));
    a1 = int'($urandom_range(1, 255)); b1 = int'($urandom_range(1, 255));
    p0 = a0 * b0; p1 = a1 * b1;
    run_op(a0, b0, 1'b1, 1'b0, 1'b0);
    checks++; if (r_o !== W'(p0 % 256) || r_s !== 1'b1) begin errors++; $display("FAIL b2b_first: got o=%0d s=%b expected o=%0d s=1", r_o, r_s, p0 % 256); end
    run_op(a1, b1, 1'b1, 1'b1, 1'b0);
    checks++; if (r_hold_o !== W'(p0 % 256)) begin errors++; $display("FAIL b2b_hold: got %0d expected %0d", r_hold_o, p0 % 256); end
    checks++; if (r_lat != W + 1) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", r_lat, W + 1); end
    checks++; if ({r_o, r_ovf, r_s} !== {W'(p1 % 256), p1 > 255, 1'b0})
      begin errors++; $display("FAIL b2b_second: got o=%0d ovf=%b s=%b expected o=%0d ovf=%b s=0", r_o, r_ovf, r_s, p1 % 256, p1 > 255); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit seen;
    run_op(13, 11, 1'b0, 1'b1, 1'b0);
    checks++; if (r_o !== W'(143) || r_s !== 1'b1) begin errors++; $display("FAIL abort_pre: got o=%0d s=%b expected o=143 s=1", r_o, r_s); end
    @(negedge clk);
    i1 = W'(200); i2 = W'(3); s1 = 1'b1; s2 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, s, ovf} !== 4'b0000 || o !== '0)
      begin errors++; $display("FAIL abort_state: got busy=%b done=%b o=%0d s=%b ovf=%b expected all 0", busy, done, o, s, ovf); end
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done: got activity after reset expected none"); end
    run_op(200, 3, 1'b1, 1'b0, 1'b0);
    checks++; if (r_lat != W + 1 || r_o !== W'(600 % 256) || r_ovf !== 1'b1 || r_s !== 1'b1)
      begin errors++; $display("FAIL abort_recover: got lat=%0d o=%0d ovf=%b s=%b expected lat=%0d o=%0d ovf=1 s=1", r_lat, r_o, r_ovf, r_s, W + 1, 600 % 256); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int a, b, prod;
    bit sa, sb;
    for (int k = 0; k < 30; k++) begin
      a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255));
      if (k % 7 == 3) a = 0;
      sa = 1'($urandom); sb = 1'($urandom);
      run_op(a, b, sa, sb, 1'($urandom));
      prod = a * b;
      checks++; if (r_lat != W + 1 || r_to) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", k, r_lat, W + 1); end
      checks++; if ({r_o, r_ovf, r_s} !== {W'(prod % 256), prod > 255, (prod != 0) && (sa ^ sb)})
        begin errors++; $display("FAIL rnd%0d_result: got o=%0d ovf=%b s=%b expected o=%0d ovf=%b s=%b (a=%0d b=%0d)", k, r_o, r_ovf, r_s, prod % 256, prod > 255, (prod != 0) && (sa ^ sb), a, b); end
`ifdef BIT8_MULTI_FULL_EN
      checks++; if (r_full !== 16'(prod)) begin errors++; $display("FAIL rnd%0d_pfull: got %0d expected %0d", k, r_full, prod); end
`endif
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    i1 = '0; i2 = '0; s1 = 1'b0; s2 = 1'b0;
    test_reset();
    test_directed();
    test_disturb();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
